// File: rtl/seg7_anim_sequencer_if.sv
// rtl/seg7_anim_sequencer_if.sv - button/table inputs and display outputs of seg7_anim_sequencer
interface seg7_anim_sequencer_if #(
  parameter int NUM_DIGITS = 4,
  parameter int NUM_ANIM   = 34,
  parameter int FRAME_W    = 6,
  parameter int TICK_W     = 25
);
  localparam int ANIM_W = (NUM_ANIM > 1) ? $clog2(NUM_ANIM) : 1;
  localparam int SCAN_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic                  anim_inc;
  logic                  anim_dec;
  logic                  speed_up;
  logic                  speed_dn;
  logic                  pause;
  logic                  step;
  logic                  mode;
  logic [FRAME_W-1:0]    frame_limit;
  logic [ANIM_W-1:0]     anim;
  logic [FRAME_W-1:0]    frame;
  logic                  frame_tick;
  logic [TICK_W-1:0]     period;
  logic [SCAN_W-1:0]     scan_idx;
  logic [NUM_DIGITS-1:0] dig_en;

  modport master (
    output anim_inc, anim_dec, speed_up, speed_dn, pause, step, mode, frame_limit,
    input  anim, frame, frame_tick, period, scan_idx, dig_en
  );

  modport slave (
    input  anim_inc, anim_dec, speed_up, speed_dn, pause, step, mode, frame_limit,
    output anim, frame, frame_tick, period, scan_idx, dig_en
  );
endinterface

// File: rtl/seg7_anim_sequencer.sv
// rtl/seg7_anim_sequencer.sv - multi-digit seven-segment animation sequencer (anim/frame/speed/scan)
// Optional ping-pong playback: define SEG7_ANIM_PINGPONG_EN.
module seg7_anim_sequencer #(
  parameter int NUM_DIGITS    = 4,
  parameter int NUM_ANIM      = 34,
  parameter int FRAME_W       = 6,
  parameter int TICK_W        = 25,
  parameter int SPEED_DEFAULT = 10_000_000,
  parameter int SPEED_MIN     = 1_000_000,
  parameter int SPEED_MAX     = 20_000_000,
  parameter int SPEED_STEP    = 1_000_000,
  parameter int SCAN_DIV      = 10_000
) (
  input logic                  clk,
  input logic                  rst_n,
  seg7_anim_sequencer_if.slave bus
);
  localparam int ANIM_W = (NUM_ANIM > 1) ? $clog2(NUM_ANIM) : 1;
  localparam int SCAN_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [ANIM_W-1:0] ANIM_LAST = ANIM_W'(NUM_ANIM - 1);
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [TICK_W:0]   MIN_X     = (TICK_W + 1)'(SPEED_MIN);
  localparam logic [TICK_W:0]   MAX_X     = (TICK_W + 1)'(SPEED_MAX);
  localparam logic [TICK_W:0]   STEP_X    = (TICK_W + 1)'(SPEED_STEP);

  logic [TICK_W-1:0]  cnt;
  logic [DIV_W-1:0]   div;
  logic               adv;
  logic               anim_chg;
  logic [ANIM_W-1:0]  anim_next;
  logic [FRAME_W-1:0] frame_adv;
  logic [TICK_W:0]    per_up;
  logic [TICK_W:0]    per_dn;
  logic [SCAN_W-1:0]  scan_next;
  logic               unused_bits;

`ifdef SEG7_ANIM_PINGPONG_EN
  logic dir_dn;
  assign unused_bits = per_up[TICK_W] ^ per_dn[TICK_W];
`else
  assign unused_bits = per_up[TICK_W] ^ per_dn[TICK_W] ^ bus.mode;
`endif

  assign anim_chg       = bus.anim_inc ^ bus.anim_dec;
  assign adv            = bus.pause ? bus.step : (cnt >= bus.period);
  assign bus.frame_tick = adv & ~anim_chg;
  assign scan_next      = (bus.scan_idx == SCAN_LAST) ? '0 : bus.scan_idx + 1'b1;

  // Widened arithmetic keeps the clamps honest near zero and near 2^TICK_W.
  assign per_up = ({1'b0, bus.period} < MIN_X + STEP_X) ? MIN_X : {1'b0, bus.period} - STEP_X;
  assign per_dn = ({1'b0, bus.period} + STEP_X > MAX_X) ? MAX_X : {1'b0, bus.period} + STEP_X;

  always_comb begin
    if (bus.anim_inc) anim_next = (bus.anim == ANIM_LAST) ? '0 : bus.anim + 1'b1;
    else              anim_next = (bus.anim == '0) ? ANIM_LAST : bus.anim - 1'b1;
  end

  always_comb begin
    frame_adv = (bus.frame >= bus.frame_limit) ? '0 : bus.frame + 1'b1;
`ifdef SEG7_ANIM_PINGPONG_EN
    if (bus.mode) begin
      if (!dir_dn)
        frame_adv = (bus.frame < bus.frame_limit) ? bus.frame + 1'b1 :
                    (bus.frame_limit == '0) ? '0 : bus.frame_limit - 1'b1;
      else
        frame_adv = (bus.frame != '0) ? bus.frame - 1'b1 :
                    (bus.frame_limit == '0) ? '0 : FRAME_W'(1);
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.anim     <= '0;
      bus.frame    <= '0;
      bus.period   <= TICK_W'(SPEED_DEFAULT);
      bus.scan_idx <= '0;
      bus.dig_en   <= NUM_DIGITS'(1);
      cnt          <= '0;
      div          <= '0;
`ifdef SEG7_ANIM_PINGPONG_EN
      dir_dn       <= 1'b0;
`endif
    end else begin
      if (anim_chg) begin
        bus.anim  <= anim_next;
        bus.frame <= '0;
        cnt       <= '0;
      end else begin
        if (!bus.pause) cnt <= (cnt >= bus.period) ? '0 : cnt + 1'b1;
        if (adv) bus.frame <= frame_adv;
      end
`ifdef SEG7_ANIM_PINGPONG_EN
      if (anim_chg || !bus.mode)
        dir_dn <= 1'b0;
      else if (adv && !dir_dn && bus.frame >= bus.frame_limit)
        dir_dn <= 1'b1;
      else if (adv && dir_dn && bus.frame == '0)
        dir_dn <= 1'b0;
`endif
      if (bus.speed_up ^ bus.speed_dn)
        bus.period <= bus.speed_up ? per_up[TICK_W-1:0] : per_dn[TICK_W-1:0];
      // The scan free-runs; nothing but reset touches it.
      if (div == DIV_LAST) begin
        div          <= '0;
        bus.scan_idx <= scan_next;
        bus.dig_en   <= NUM_DIGITS'(1) << scan_next;
      end else begin
        div <= div + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg7_anim_sequencer.sv
// tb/tb_seg7_anim_sequencer.sv - directed, table-driven bench for seg7_anim_sequencer
module tb_seg7_anim_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  seg7_anim_sequencer_if #(.NUM_DIGITS(4), .NUM_ANIM(4), .FRAME_W(6), .TICK_W(8)) bus ();

  seg7_anim_sequencer #(
    .NUM_DIGITS(4), .NUM_ANIM(4), .FRAME_W(6), .TICK_W(8),
    .SPEED_DEFAULT(10), .SPEED_MIN(2), .SPEED_MAX(20), .SPEED_STEP(4), .SCAN_DIV(3)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  typedef struct {
    logic inc, dec, up, dn;
    int   exp_anim;
    int   exp_period;
  } vec_t;
  vec_t vecs[19];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.anim_inc = 0; bus.anim_dec = 0; bus.speed_up = 0; bus.speed_dn = 0;
    bus.step = 0;
  endtask

  // Ends at a negedge with reset just released; checks state is cleared asynchronously.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    #1;
    chk("rst_anim", int'(bus.anim), 0);
    chk("rst_frame", int'(bus.frame), 0);
    chk("rst_period", int'(bus.period), 10);
    chk("rst_dig_en", int'(bus.dig_en), 1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
      clear_inputs();
    end
  endtask

  // Runs until n ticks are seen, checking the frame committed by each.
  task automatic run_ticks(input string name, input int exp_q[$]);
    int seen = 0;
    int budget = 12 * exp_q.size() + 20;
    while (seen < exp_q.size() && budget > 0) begin
      logic t;
      #1 t = bus.frame_tick;
      @(posedge clk);
      #1;
      if (t) begin
        chk(name, int'(bus.frame), exp_q[seen]);
        seen++;
      end
      budget--;
      @(negedge clk);
    end
    if (seen < exp_q.size()) chk({name, "_timeout"}, seen, exp_q.size());
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 6};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 2};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 2};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 2};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 2};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 6};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 10};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 14};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 18};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 20};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 20};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 0, 20};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1, 20};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 2, 20};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 3, 20};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 20};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 3, 20};
    vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 3, 20};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 1'b0, 2, 20};

    clear_inputs();
    bus.pause = 0;
    bus.mode = 0;
    bus.frame_limit = 6'd2;

    // Free-running ticks at cycles 11, 22, 33; frames 1, 2, 0.
    do_reset();
    chk("rst_tick", int'(bus.frame_tick), 0);
    chk("rst_scan_idx", int'(bus.scan_idx), 0);
    begin
      int fi = 0;
      int exp_frames[3] = '{1, 2, 0};
      for (int c = 1; c <= 33; c++) begin
        #1 chk("tick_at_cycle", int'(bus.frame_tick), (c % 11 == 0) ? 1 : 0);
        @(posedge clk);
        #1;
        if (c % 11 == 0) begin
          chk("tick_frame", int'(bus.frame), exp_frames[fi]);
          fi++;
        end
        @(negedge clk);
      end
    end
    chk("tick_period", int'(bus.period), 10);

    // Speed and animation pulses, paused so only the pulses matter.
    do_reset();
    bus.pause = 1;
    for (int i = 0; i < 19; i++) begin
      bus.anim_inc = vecs[i].inc; bus.anim_dec = vecs[i].dec;
      bus.speed_up = vecs[i].up;  bus.speed_dn = vecs[i].dn;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_anim", i), int'(bus.anim), vecs[i].exp_anim);
      chk($sformatf("vec%0d_period", i), int'(bus.period), vecs[i].exp_period);
      chk($sformatf("vec%0d_frame", i), int'(bus.frame), 0);
      @(negedge clk);
      clear_inputs();
    end
    bus.pause = 0;

    // anim_inc in the tick cycle drops the advance and restarts the counter.
    do_reset();
    idle(10);
    bus.anim_inc = 1;
    #1 chk("chg_tick_suppressed", int'(bus.frame_tick), 0);
    @(posedge clk);
    #1;
    chk("chg_anim", int'(bus.anim), 1);
    chk("chg_frame", int'(bus.frame), 0);
    @(negedge clk);
    clear_inputs();
    for (int k = 1; k <= 11; k++) begin
      #1 chk("chg_cnt_restart", int'(bus.frame_tick), (k == 11) ? 1 : 0);
      @(negedge clk);
    end

    // Pause freezes frame and counter; step advances only while paused.
    bus.frame_limit = 6'd5;
    do_reset();
    idle(5);
    bus.pause = 1;
    for (int i = 0; i < 50; i++) begin
      #1 chk("pause_no_tick", int'(bus.frame_tick), 0);
      @(negedge clk);
    end
    chk("pause_frame", int'(bus.frame), 0);
    for (int i = 1; i <= 3; i++) begin
      bus.step = 1;
      #1 chk("step_tick", int'(bus.frame_tick), 1);
      @(posedge clk);
      #1 chk("step_frame", int'(bus.frame), i);
      @(negedge clk);
      clear_inputs();
      idle(1);
    end
    bus.pause = 0;
    bus.step = 1;
    #1 chk("step_unpaused_tick", int'(bus.frame_tick), 0);
    @(posedge clk);
    #1 chk("step_unpaused_frame", int'(bus.frame), 3);
    @(negedge clk);
    clear_inputs();
    begin
      int k = 0;
      logic seen = 0;
      while (!seen && k < 30) begin
        k++;
        #1 seen = bus.frame_tick;
        @(negedge clk);
      end
      chk("pause_cnt_held", k, 5);
      chk("resume_frame", int'(bus.frame), 4);
    end

    // Scan keeps its cadence through pause and animation change.
    bus.frame_limit = 6'd2;
    do_reset();
    for (int c = 0; c < 15; c++) begin
      int e;
      bus.pause = (c >= 4 && c <= 8);
      bus.anim_inc = (c == 6);
      e = 1 << ((c / 3) % 4);
      #1;
      chk($sformatf("scan_dig_en_c%0d", c), int'(bus.dig_en), e);
      chk($sformatf("scan_idx_c%0d", c), int'(bus.scan_idx), (c / 3) % 4);
      @(negedge clk);
    end
    clear_inputs();
    bus.pause = 0;

`ifdef SEG7_ANIM_PINGPONG_EN
    bus.mode = 1;
    bus.frame_limit = 6'd3;
    do_reset();
    run_ticks("pp_frame", '{1, 2, 3, 2, 1, 0, 1});
    bus.frame_limit = 6'd0;
    do_reset();
    run_ticks("pp_zero_limit", '{0, 0, 0});
    bus.mode = 0;
`endif

    // Wrap playback with a limit shrunk below the current frame.
    bus.frame_limit = 6'd5;
    do_reset();
    run_ticks("wrap_frame", '{1, 2, 3});
    bus.frame_limit = 6'd1;
    run_ticks("shrink_frame", '{0, 1, 0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d checks, expected completion", n_tests);
    $fatal(1);
  end
endmodule
